// File: rtl/seg_serial_tx.sv
// Purpose: shifts a DATA_BITS-wide segment pattern out on s_clk/sout into chained 7-segment shift registers.
// Latency: first SHIFT_LO cycle follows the posedge that sees a start rising edge; frame = 2*CLK_DIV*DATA_BITS cycles, then a 1-cycle done.
// Backpressure: none; start edges while a frame is in flight are dropped, not queued. Optional macro SEG_SERIAL_BLANK_EN blanks EN while shifting.
module seg_serial_tx #(
    parameter int DATA_BITS = 64,
    parameter int CLK_DIV   = 2,
    parameter int DIR       = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] pdata,
    output logic                 busy,
    output logic                 done,
    output logic                 s_clk,
    output logic                 s_clrn,
    output logic                 sout,
    output logic                 EN
);

    localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 start_q;
    logic                 start_edge;
    logic                 phase_end;
    logic                 cur_bit;
    logic [DATA_BITS-1:0] sr;
    logic [CNT_W-1:0]     cnt;
    logic [DIV_W-1:0]     div;

    assign start_edge = start & ~start_q;
    assign phase_end  = (div == DIV_LAST);
    // The output end of the shift register depends on the shift direction.
    assign cur_bit    = (DIR == 0) ? sr[DATA_BITS-1] : sr[0];

    // State register; reset aborts any frame in flight without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: each half-period lasts CLK_DIV cycles; the last bit's high phase leads to DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start_edge) state_nxt = SHIFT_LO;
            SHIFT_LO: if (phase_end) state_nxt = SHIFT_HI;
            SHIFT_HI: if (phase_end) state_nxt = (cnt == LAST_BIT) ? DONE : SHIFT_LO;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Datapath: start edge history, chain clear release, pattern capture, bit and divider counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            s_clrn  <= 1'b0;
            sr      <= '0;
            cnt     <= '0;
            div     <= '0;
        end else begin
            start_q <= start;
            s_clrn  <= 1'b1;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        sr  <= pdata;
                        cnt <= '0;
                        div <= '0;
                    end
                end
                SHIFT_LO: begin
                    div <= phase_end ? '0 : div + 1'b1;
                end
                SHIFT_HI: begin
                    if (phase_end) begin
                        div <= '0;
                        // Shift only on the low-going s_clk edge so sout never moves while s_clk is high.
                        if (cnt != LAST_BIT) begin
                            cnt <= cnt + 1'b1;
                            if (DIR == 0) begin
                                sr <= {sr[DATA_BITS-2:0], 1'b1};
                            end else begin
                                sr <= {1'b1, sr[DATA_BITS-1:1]};
                            end
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                default: begin
                    div <= '0;
                end
            endcase
        end
    end

    // Outputs decode registered state only, so nothing on an input reaches an output combinationally.
    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        s_clk = 1'b0;
        sout  = 1'b0;
        EN    = 1'b1;
        case (state)
            SHIFT_LO: begin
                busy = 1'b1;
                sout = cur_bit;
`ifdef SEG_SERIAL_BLANK_EN
                EN   = 1'b0;
`endif
            end
            SHIFT_HI: begin
                busy  = 1'b1;
                s_clk = 1'b1;
                sout  = cur_bit;
`ifdef SEG_SERIAL_BLANK_EN
                EN    = 1'b0;
`endif
            end
            DONE: begin
                done = 1'b1;
`ifdef SEG_SERIAL_BLANK_EN
                EN   = 1'b0;
`endif
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
